// File: rtl/timer_arbiter.sv
// Round-robin arbiter that shares one load/elapsed timer among NUM_REQ clients.
// Each grant loads the timer with the owner's requested cycle count and returns a 1-cycle done.
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_cycles,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     timer_load,
  output logic [WIDTH-1:0]         timer_cycles,
  input  logic                     timer_elapsed
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic [WIDTH-1:0]     tcyc_q, tcyc_d;

  logic [WIDTH-1:0]     cyc_arr [NUM_REQ];
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [IW:0]          arb_sum;
  logic [IW:0]          arb_wrap;
  logic [IW-1:0]        owner_inc;
  logic [WIDTH-1:0]     pick_cycles;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cyc
      assign cyc_arr[gi] = req_cycles[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the highest offset down so the closest set bit at/after ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    arb_sum    = '0;
    arb_wrap   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_sum  = {1'b0, ptr_q} + (IW+1)'(k);
      arb_wrap = (arb_sum >= (IW+1)'(NUM_REQ)) ? arb_sum - (IW+1)'(NUM_REQ) : arb_sum;
      if (req[arb_wrap[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = arb_wrap[IW-1:0];
      end
    end
  end

  assign pick_cycles = cyc_arr[pick_idx];
  assign owner_inc   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = '0;
    load_d  = 1'b0;
    tcyc_d  = tcyc_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          if (pick_cycles == '0) begin
            // Zero timeout completes without touching the timer.
            done_d[pick_idx] = 1'b1;
            ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end else begin
            state_d          = LOAD;
            load_d           = 1'b1;
            tcyc_d           = pick_cycles;
            gnt_d[pick_idx]  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d         = WAIT;
        gnt_d[owner_q]  = 1'b1;
      end
      WAIT: begin
        // Elapsed takes precedence over a simultaneous abort.
        if (timer_elapsed) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
          ptr_d           = owner_inc;
        end else if (!req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else begin
          gnt_d[owner_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      tcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      tcyc_q  <= tcyc_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign timer_load   = load_q;
  assign timer_cycles = tcyc_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: the driver queues expected load/done events,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_cycles = '0;
  logic           timer_elapsed = 1'b0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           timer_load;
  logic [W-1:0]   timer_cycles;

  timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cycles(req_cycles),
    .gnt(gnt), .done(done), .busy(busy), .timer_load(timer_load),
    .timer_cycles(timer_cycles), .timer_elapsed(timer_elapsed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_done;
    logic [N-1:0] vec;
    logic [W-1:0] cv;
    int           at;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [N-1:0] v, input logic [W-1:0] c, input int at);
    exp_t e;
    e.is_done = 1'b0; e.vec = v; e.cv = c; e.at = at;
    q.push_back(e);
    $display("expect load gnt=%b cycles=%0d at cycle %0d", v, c, at);
  endtask

  task automatic push_done(input logic [N-1:0] v, input int at);
    exp_t e;
    e.is_done = 1'b1; e.vec = v; e.cv = '0; e.at = at;
    q.push_back(e);
    $display("expect done=%b at cycle %0d", v, at);
  endtask

  task automatic set_cyc(input int i, input logic [W-1:0] v);
    req_cycles[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    timer_elapsed = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(timer_load), 0);
    step();
    rst = 1'b0;
  endtask

  // Monitor: compares every presented load/done against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if ((gnt | done) != '0) begin
        chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
        chk("done_gnt_overlap", 32'(done & gnt), 0);
      end
      if (timer_load || done != '0) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_event: load=%b gnt=%b done=%b required none (cycle %0d)",
                   timer_load, gnt, done, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_done) begin
            $display("cycle %0d done=%b gnt=%b", cyc, done, gnt);
            chk("done_vec", 32'(done), 32'(e.vec));
            chk("done_cycle", cyc, e.at);
            chk("done_gnt_clear", 32'(gnt), 0);
          end else begin
            $display("cycle %0d load=%b gnt=%b cycles=%0d", cyc, timer_load, gnt, timer_cycles);
            chk("load_strobe", 32'(timer_load), 1);
            chk("load_gnt", 32'(gnt), 32'(e.vec));
            chk("load_cycles", 32'(timer_cycles), 32'(e.cv));
            chk("load_cycle", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2;
    do_reset();

    // 1: single request, cycles=5
    set_cyc(0, 16'd5);
    req = 4'b0001;
    t = cyc;
    push_load(4'b0001, 16'd5, t + 1);
    step();
    chk("t1_busy_load", 32'(busy), 1);
    step();
    timer_elapsed = 1'b1;
    push_done(4'b0001, t + 3);
    step();
    timer_elapsed = 1'b0;
    req = '0;
    chk("t1_busy_idle", 32'(busy), 0);
    step();

    // 2: all four held, round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_cyc(i, 16'd3);
    req = 4'b1111;
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      push_load(4'(1 << (k % 4)), 16'd3, t + 1);
      step();
      step();
      timer_elapsed = 1'b1;
      push_done(4'(1 << (k % 4)), t + 3);
      step();
      timer_elapsed = 1'b0;
      t = cyc;
      if (k == 4) req = '0;
    end
    step();

    // 3: zero timeout on requester 2
    set_cyc(2, 16'd0);
    req = 4'b0100;
    t = cyc;
    push_done(4'b0100, t + 1);
    step();
    req = '0;
    chk("t3_gnt", 32'(gnt), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_load", 32'(timer_load), 0);
    step();
    step();

    // 4: owner 1 aborts, pending 3 granted; then elapsed+abort together
    do_reset();
    set_cyc(1, 16'd7);
    set_cyc(3, 16'd9);
    req = 4'b1010;
    t = cyc;
    push_load(4'b0010, 16'd7, t + 1);
    step();
    step();
    req = 4'b1000;
    step();
    chk("t4_abort_gnt", 32'(gnt), 0);
    chk("t4_abort_done", 32'(done), 0);
    push_load(4'b1000, 16'd9, t + 4);
    step();
    step();
    timer_elapsed = 1'b1;
    req = '0;
    push_done(4'b1000, t + 6);
    step();
    timer_elapsed = 1'b0;
    step();

    // 5: stale elapsed in IDLE and LOAD is ignored
    do_reset();
    t = cyc;
    timer_elapsed = 1'b1;
    step();
    timer_elapsed = 1'b0;
    set_cyc(0, 16'd4);
    req = 4'b0001;
    push_load(4'b0001, 16'd4, t + 2);
    step();
    timer_elapsed = 1'b1;
    step();
    timer_elapsed = 1'b0;
    chk("t5_wait_gnt", 32'(gnt), 32'(4'b0001));
    chk("t5_no_done", 32'(done), 0);
    step();
    chk("t5_still_gnt", 32'(gnt), 32'(4'b0001));
    timer_elapsed = 1'b1;
    req = '0;
    push_done(4'b0001, t + 5);
    step();
    timer_elapsed = 1'b0;
    step();
    step();
    chk("t5_tcyc_hold", 32'(timer_cycles), 4);

    // 6: move pointer to 2, reset mid-WAIT, pointer must be back at 0
    set_cyc(1, 16'd0);
    req = 4'b0010;
    t = cyc;
    push_done(4'b0010, t + 1);
    step();
    set_cyc(0, 16'd100);
    req = 4'b0001;
    push_load(4'b0001, 16'd100, t + 2);
    step();
    step();
    step();
    chk("t6_pre_rst_gnt", 32'(gnt), 32'(4'b0001));
    do_reset();
    set_cyc(1, 16'd6);
    set_cyc(2, 16'd8);
    req = 4'b0110;
    t = cyc;
    push_load(4'b0010, 16'd6, t + 1);
    step();
    step();
    timer_elapsed = 1'b1;
    req = '0;
    push_done(4'b0010, t + 3);
    step();
    timer_elapsed = 1'b0;
    step();
    step();

    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
